// File: rtl/updown_counter_param.sv
// updown_counter_param
//   Parametrised up/down counter over the range 0..MODULO-1 (MODULO need not
//   be a power of two). It has a synchronous load, a count enable, and an
//   end-of-range behaviour chosen at runtime: wrap, saturate or one-shot.
//   It can be cascaded for multi-digit counters: digit n+1 en = en_n & tc_n.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, overrides everything
//   en       in   count enable (cnt holds when low)
//   ld       in   synchronous load of d (beats en, honoured even when en=0)
//   up       in   1 = increment, 0 = decrement
//   mode     in   00 wrap, 01 saturate, 10 one-shot, 11 reserved (= wrap)
//   d        in   load value; out-of-range values clamp to MODULO-1
//   cnt      out  registered count, always < MODULO
//   tc       out  combinational terminal count (depends only on cnt, up)
//   wrap     out  registered pulse, the cycle after the count wrapped
//   done     out  registered sticky flag set by one-shot at terminal
//   ld_clamp out  registered pulse, the last load was clamped
module updown_counter_param #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ld,
  input  logic             up,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  output logic             ld_clamp
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             ld_clamp_q, ld_clamp_d;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  // Terminal depends on direction. The increment/decrement below therefore
  // never crosses 0 or MAX_VAL, so plain WIDTH-bit arithmetic stays in
  // range even when MODULO is not a power of two.
  assign tc = up ? (cnt_q == MAX_VAL) : (cnt_q == '0);

  always_comb begin
    cnt_d      = cnt_q;
    wrap_d     = 1'b0;
    done_d     = done_q;
    ld_clamp_d = 1'b0;
    if (ld) begin
      done_d = 1'b0;
      if (d > MAX_VAL) begin
        cnt_d      = MAX_VAL;
        ld_clamp_d = 1'b1;
      end else begin
        cnt_d = d;
      end
    end else if (en && !done_q) begin
      // Once done is set the count is frozen until a load or reset.
      if (!tc) begin
        cnt_d = up ? cnt_q + ONE : cnt_q - ONE;
      end else begin
        case (mode_s)
          MODE_SAT:     ;
          MODE_ONESHOT: done_d = 1'b1;
          default: begin
            // Wrap mode; reserved mode 11 also lands here.
            cnt_d  = up ? '0 : MAX_VAL;
            wrap_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      ld_clamp_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      ld_clamp_q <= ld_clamp_d;
    end
  end

  assign cnt      = cnt_q;
  assign wrap     = wrap_q;
  assign done     = done_q;
  assign ld_clamp = ld_clamp_q;

endmodule
